// File: rtl/wide_addsub4_serial_if.sv
// wide_addsub4_serial_if: operand and result handshake bundle
// for the folded 4-operand signed add/subtract reducer.
interface wide_addsub4_serial_if #(
    parameter int IN_WIDTH = 251
);
    localparam int OW = IN_WIDTH + 2;

    logic                       in_valid;
    logic                       in_ready;
    logic signed [IN_WIDTH-1:0] A;
    logic signed [IN_WIDTH-1:0] B;
    logic signed [IN_WIDTH-1:0] C;
    logic signed [IN_WIDTH-1:0] D;
    logic signed [OW-1:0]       S;
    logic                       out_valid;
    logic                       out_ready;

    modport master (
        output in_valid, A, B, C, D, out_ready,
        input  in_ready, S, out_valid
    );

    modport slave (
        input  in_valid, A, B, C, D, out_ready,
        output in_ready, S, out_valid
    );
endinterface

// File: rtl/wide_addsub4_serial.sv
// wide_addsub4_serial: S = A +/- B +/- C +/- D on wide signed
// operands, one STAGE_WIDTH chunk per cycle, LSB chunk first.
module wide_addsub4_serial #(
    parameter int IN_WIDTH    = 251,
    parameter int STAGE_WIDTH = 64,
    parameter bit SUB_B       = 1'b0,
    parameter bit SUB_C       = 1'b0,
    parameter bit SUB_D       = 1'b0
) (
    input logic                  clk,
    input logic                  resetn,
    wide_addsub4_serial_if.slave bus
);
    localparam int SW  = STAGE_WIDTH;
    localparam int OW  = IN_WIDTH + 2;
    localparam int NCH = (OW + SW - 1) / SW;
    localparam int PW  = NCH * SW;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [SW-1:0] MB = {SW{SUB_B}};
    localparam logic [SW-1:0] MC = {SW{SUB_C}};
    localparam logic [SW-1:0] MD = {SW{SUB_D}};
    localparam logic [1:0]    CIN = 2'(SUB_B) + 2'(SUB_C) + 2'(SUB_D);
    localparam logic [PW-1:0] CMASK = PW'({SW{1'b1}});

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            live;
    logic [KW-1:0]   k;
    logic [1:0]      carry;
    logic [OW-1:0]   a_r;
    logic [OW-1:0]   b_r;
    logic [OW-1:0]   c_r;
    logic [OW-1:0]   d_r;
    logic [OW-1:0]   s_r;
    logic [SW-1:0]   a_k;
    logic [SW-1:0]   b_k;
    logic [SW-1:0]   c_k;
    logic [SW-1:0]   d_k;
    logic [SW+1:0]   sum;
    logic [31:0]     sh;
    logic            accept;
    logic            last;

    // Sign-extend an operand to the full result width.
    function automatic logic [OW-1:0] sext(input logic [IN_WIDTH-1:0] x);
        return {{2{x[IN_WIDTH-1]}}, x};
    endfunction

    // State register; live keeps in_ready low until the first edge out of reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            live  <= 1'b0;
        end else begin
            state <= state_nxt;
            live  <= 1'b1;
        end
    end

    // Next-state logic; unused encodings fall back to IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: if (last) state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state; S is the held result register.
    always_comb begin
        bus.in_ready  = live && (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.S         = s_r;
    end

    // Chunk select and the single shared 4-input chunk adder.
    always_comb begin
        accept = bus.in_valid && bus.in_ready;
        last   = (k == KW'(NCH - 1));
        sh     = 32'(k) * 32'(SW);
        a_k    = SW'(PW'(a_r) >> sh);
        b_k    = SW'(PW'(b_r) >> sh);
        c_k    = SW'(PW'(c_r) >> sh);
        d_k    = SW'(PW'(d_r) >> sh);
        sum    = (SW+2)'(a_k) + (SW+2)'(b_k ^ MB)
               + (SW+2)'(c_k ^ MC) + (SW+2)'(d_k ^ MD)
               + (SW+2)'(carry);
    end

    // Capture operands at accept, then write one result chunk per CALC cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_r   <= '0;
            b_r   <= '0;
            c_r   <= '0;
            d_r   <= '0;
            s_r   <= '0;
            carry <= '0;
            k     <= '0;
        end else if (accept) begin
            a_r   <= sext(bus.A);
            b_r   <= sext(bus.B);
            c_r   <= sext(bus.C);
            d_r   <= sext(bus.D);
            carry <= CIN;
            k     <= '0;
        end else if (state == CALC) begin
            s_r   <= (s_r & ~OW'(CMASK << sh))
                   | OW'(PW'(sum[SW-1:0]) << sh);
            carry <= sum[SW+1:SW];
            if (!last) k <= k + 1'b1;
        end
    end
endmodule

// File: tb/tb_wide_addsub4_serial.sv
// tb_wide_addsub4_serial: directed table, handshake corner cases and
// randomized back-to-back traffic for five SUB configurations.
module tb_wide_addsub4_serial;
    localparam int IW  = 251;
    localparam int OW  = 253;
    localparam int NCH = 4;
    localparam int NI  = 5;
    // instance 0..4 -> SUB(B,C,D) = 000, 011, 111, 101, 110
    localparam logic [14:0] CFGS = {3'b110, 3'b101, 3'b111, 3'b011, 3'b000};

    typedef struct {
        int            ci;
        logic [IW-1:0] a;
        logic [IW-1:0] b;
        logic [IW-1:0] c;
        logic [IW-1:0] d;
        logic [OW-1:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          iv   [NI];
    logic          ordy [NI];
    logic          ir   [NI];
    logic          ov   [NI];
    logic [OW-1:0] so   [NI];
    logic [IW-1:0] opa, opb, opc, opd;
    int            n_pass = 0;
    int            n_total = 0;
    vec_t          tv [8];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam logic [2:0] SC = CFGS[3*g +: 3];
        wide_addsub4_serial_if #(.IN_WIDTH(IW)) bus ();
        assign bus.in_valid  = iv[g];
        assign bus.A         = opa;
        assign bus.B         = opb;
        assign bus.C         = opc;
        assign bus.D         = opd;
        assign bus.out_ready = ordy[g];
        assign ir[g]         = bus.in_ready;
        assign ov[g]         = bus.out_valid;
        assign so[g]         = bus.S;
        wide_addsub4_serial #(
            .IN_WIDTH(IW), .STAGE_WIDTH(64),
            .SUB_B(SC[2]), .SUB_C(SC[1]), .SUB_D(SC[0])
        ) dut (
            .clk(clk), .resetn(resetn), .bus(bus)
        );
    end

    function automatic logic [2:0] cfg_of(input int ci);
        case (ci)
            0: return 3'b000;
            1: return 3'b011;
            2: return 3'b111;
            3: return 3'b101;
            default: return 3'b110;
        endcase
    endfunction

    function automatic logic [OW-1:0] model(input logic [2:0] sub,
        input logic [IW-1:0] a, input logic [IW-1:0] b,
        input logic [IW-1:0] c, input logic [IW-1:0] d);
        logic signed [OW-1:0] r, eb, ec, ed;
        r  = $signed(a);
        eb = $signed(b);
        ec = $signed(c);
        ed = $signed(d);
        if (sub[2]) r = r - eb; else r = r + eb;
        if (sub[1]) r = r - ec; else r = r + ec;
        if (sub[0]) r = r - ed; else r = r + ed;
        return r;
    endfunction

    function automatic logic [IW-1:0] rnd();
        logic [255:0] t;
        int m;
        m = $urandom_range(0, 7);
        for (int i = 0; i < 8; i++) t[32*i +: 32] = $urandom;
        if (m == 0) begin
            t = '0;
            t[IW-2:0] = '1;
        end else if (m == 1) begin
            t = '0;
            t[IW-1] = 1'b1;
        end else if (m == 2) begin
            t = '1;
        end
        return t[IW-1:0];
    endfunction

    task automatic chk(input string nm, input logic [OW-1:0] act,
                       input logic [OW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    task automatic wait_rdy(input int ci, output bit ok);
        int n = 0;
        while (!ir[ci] && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = ir[ci];
    endtask

    // One transaction with out_ready held high; checks timing and result.
    task automatic run_op(input int ci, input vec_t v, input string nm);
        int lat;
        bit ok;
        wait_rdy(ci, ok);
        chk({nm, "/ready"}, OW'(ok), OW'(1));
        opa = v.a; opb = v.b; opc = v.c; opd = v.d;
        iv[ci] = 1'b1;
        @(negedge clk);
        iv[ci] = 1'b0;
        chk({nm, "/in_ready_drop"}, OW'(ir[ci]), OW'(0));
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ov[ci] && lat < 20);
        chk({nm, "/latency"}, OW'(lat), OW'(NCH));
        chk({nm, "/S"}, so[ci], v.exp);
        @(negedge clk);
        chk({nm, "/out_valid_fall"}, OW'(ov[ci]), OW'(0));
        chk({nm, "/in_ready_back"}, OW'(ir[ci]), OW'(1));
    endtask

    // Back-to-back random traffic with random out_ready stalls.
    task automatic run_rand(input int ci);
        logic [OW-1:0] q[$];
        int got_n = 0;
        fork
            begin : prod
                for (int n = 0; n < 120; n++) begin
                    bit acc;
                    int w;
                    logic [OW-1:0] e;
                    opa = rnd(); opb = rnd(); opc = rnd(); opd = rnd();
                    e = model(cfg_of(ci), opa, opb, opc, opd);
                    iv[ci] = 1'b1;
                    w = 0;
                    do begin
                        acc = ir[ci];
                        @(negedge clk);
                        w++;
                    end while (!acc && w < 100);
                    if (acc) q.push_back(e);
                    else chk("rand/accept_timeout", OW'(acc), OW'(1));
                end
                iv[ci] = 1'b0;
            end
            begin : cons
                int cyc = 0;
                while (got_n < 120 && cyc < 5000) begin
                    ordy[ci] = ($urandom_range(0, 3) != 0);
                    if (ov[ci] && ordy[ci]) begin
                        if (q.size() != 0) begin
                            chk("rand/S", so[ci], q.pop_front());
                        end else begin
                            n_total++;
                            $display("FAIL rand/extra_output: got %h, want none", so[ci]);
                        end
                        got_n++;
                    end
                    @(negedge clk);
                    cyc++;
                end
                ordy[ci] = 1'b1;
            end
        join
        chk("rand/count", OW'(got_n), OW'(120));
        chk("rand/leftover", OW'(q.size()), OW'(0));
        repeat (8) @(negedge clk);
        chk("rand/no_dup", OW'(ov[ci]), OW'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int lat;
        bit ok;
        logic [OW-1:0] snap;
        vec_t v;

        for (int i = 0; i < NI; i++) begin
            iv[i]   = 1'b0;
            ordy[i] = 1'b1;
        end
        opa = '0; opb = '0; opc = '0; opd = '0;

        tv[0] = '{ci:0, a:251'd1, b:251'd1, c:251'd1, d:251'd1, exp:253'd4};
        tv[1] = '{ci:1, a:{{187{1'b0}}, {64{1'b1}}}, b:251'd1, c:251'd0,
                  d:251'd1, exp:{{189{1'b0}}, {64{1'b1}}}};
        tv[2] = '{ci:0, a:{{59{1'b0}}, {192{1'b1}}}, b:{{59{1'b0}}, {192{1'b1}}},
                  c:{{59{1'b0}}, {192{1'b1}}}, d:{{59{1'b0}}, {192{1'b1}}},
                  exp:{{59{1'b0}}, {192{1'b1}}, 2'b00}};
        tv[3] = '{ci:2, a:{1'b0, {250{1'b1}}}, b:{1'b1, {250{1'b0}}},
                  c:{1'b1, {250{1'b0}}}, d:{1'b1, {250{1'b0}}},
                  exp:{1'b0, {252{1'b1}}}};
        tv[4] = '{ci:0, a:{1'b1, {250{1'b0}}}, b:{1'b1, {250{1'b0}}},
                  c:{1'b1, {250{1'b0}}}, d:{1'b1, {250{1'b0}}},
                  exp:{1'b1, {252{1'b0}}}};
        tv[5] = '{ci:3, a:251'd10, b:251'd3, c:251'd4, d:251'd20, exp:-253'd9};
        tv[6] = '{ci:4, a:251'd5, b:251'd7, c:251'd100, d:251'd1, exp:-253'd101};
        tv[7] = '{ci:2, a:251'd0, b:251'd0, c:251'd0, d:251'd0, exp:253'd0};

        // reset state
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("reset/in_ready", OW'(ir[i]), OW'(0));
            chk("reset/out_valid", OW'(ov[i]), OW'(0));
            chk("reset/S", so[i], OW'(0));
        end
        resetn = 1'b1;
        #1;
        chk("reset/in_ready_before_edge", OW'(ir[0]), OW'(0));
        @(negedge clk);
        chk("reset/in_ready_after_edge", OW'(ir[0]), OW'(1));

        // directed table
        for (int i = 0; i < 8; i++) begin
            run_op(tv[i].ci, tv[i], $sformatf("vec%0d", i));
        end

        // backpressure: stall 10 cycles, new operands must be ignored
        wait_rdy(0, ok);
        opa = 251'd100; opb = 251'd200; opc = 251'd300; opd = 251'd400;
        iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        ordy[0] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ov[0] && lat < 20);
        chk("bp/latency", OW'(lat), OW'(NCH));
        chk("bp/S", so[0], OW'(1000));
        snap = so[0];
        opa = 251'd1; opb = 251'd2; opc = 251'd3; opd = 251'd4;
        iv[0] = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (so[0] !== snap || ov[0] !== 1'b1 || ir[0] !== 1'b0) bad++;
        end
        chk("bp/stable", OW'(bad), OW'(0));
        ordy[0] = 1'b1;
        @(negedge clk);
        chk("bp/out_valid_fall", OW'(ov[0]), OW'(0));
        chk("bp/in_ready_back", OW'(ir[0]), OW'(1));
        @(negedge clk);
        chk("bp/next_accept", OW'(ir[0]), OW'(0));
        iv[0] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ov[0] && lat < 20);
        chk("bp/next_latency", OW'(lat), OW'(NCH));
        chk("bp/next_S", so[0], OW'(10));
        @(negedge clk);

        // reset in the middle of CALC
        wait_rdy(0, ok);
        opa = 251'd1; opb = 251'd1; opc = 251'd1; opd = 251'd1;
        iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("rst/out_valid", OW'(ov[0]), OW'(0));
        chk("rst/S", so[0], OW'(0));
        chk("rst/in_ready", OW'(ir[0]), OW'(0));
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (ov[0] !== 1'b0 || ir[0] !== 1'b0 || so[0] !== '0) bad++;
        end
        resetn = 1'b1;
        #1;
        chk("rst/held", OW'(bad), OW'(0));
        @(negedge clk);
        chk("rst/in_ready_release", OW'(ir[0]), OW'(1));
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (ov[0] !== 1'b0) bad++;
        end
        chk("rst/no_result", OW'(bad), OW'(0));
        v = '{ci:3, a:251'd10, b:251'd3, c:251'd4, d:251'd20, exp:-253'd9};
        run_op(3, v, "rst/fresh");

        // random regression per configuration
        run_rand(1);
        run_rand(2);
        run_rand(3);
        run_rand(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
